// File: rtl/bank_burst_sequencer.sv
// Burst sequencer between a command host and the per-bank ports of a DRAM Chip model.
// Drives BL beats of row/column/data to one bank and assembles read beats into one burst word.
module bank_burst_sequencer #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int RDLAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [BGWIDTH-1:0]           cmd_bg,
  input  logic [BAWIDTH-1:0]           cmd_ba,
  input  logic [CHWIDTH-1:0]           cmd_row,
  input  logic [COLWIDTH-1:0]          cmd_col,
  input  logic [BL*DEVICE_WIDTH-1:0]   cmd_wdata,
  output logic                         rd_valid,
  output logic [BL*DEVICE_WIDTH-1:0]   rd_data,
  output logic                         rd_o_wr [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [DEVICE_WIDTH-1:0]      dqin    [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [CHWIDTH-1:0]           row     [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [COLWIDTH-1:0]          column  [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  input  logic [DEVICE_WIDTH-1:0]      dqout   [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0]
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WRITE   | driving write beats 0..BL-1 to the selected bank
  // RECOVER | one quiet cycle after a write burst
  // READ    | driving read beats 0..BL-1, capturing dqout RDLAT-1 cycles later
  // DRAIN   | collecting trailing read beats, then pulsing rd_valid

  localparam int NBG  = 2**BGWIDTH;
  localparam int NBA  = 2**BAWIDTH;
  localparam int DW   = DEVICE_WIDTH;
  localparam int LBL  = $clog2(BL);
  localparam int TW   = $clog2(BL + RDLAT + 1);

  localparam logic [TW-1:0]       BEAT_LAST  = TW'(BL - 1);
  localparam logic [TW-1:0]       VALID_TICK = TW'(BL + RDLAT - 1);
  localparam logic [TW-1:0]       DRAIN_LAST = TW'(BL + RDLAT);
  localparam logic [TW:0]         CAP_LO     = (TW+1)'(RDLAT);
  localparam logic [TW:0]         CAP_HI     = (TW+1)'(RDLAT + BL);
  localparam logic [COLWIDTH-1:0] WRAP_MASK  = COLWIDTH'(BL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RECOVER,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                    state_q,  state_d;
  logic [TW-1:0]             tick_q,   tick_d;
  logic [BGWIDTH-1:0]        bg_q,     bg_d;
  logic [BAWIDTH-1:0]        ba_q,     ba_d;
  logic [CHWIDTH-1:0]        row_q,    row_d;
  logic [COLWIDTH-1:0]       col_q,    col_d;
  logic [BL*DW-1:0]          wdata_q,  wdata_d;
  logic [BL*DW-1:0]          cap_q,    cap_d;
  logic [BL*DW-1:0]          rd_data_q, rd_data_d;
  logic                      rd_valid_q, rd_valid_d;

  logic                      bank_we_q  [NBG-1:0][NBA-1:0];
  logic                      bank_we_d  [NBG-1:0][NBA-1:0];
  logic [DW-1:0]             bank_dq_q  [NBG-1:0][NBA-1:0];
  logic [DW-1:0]             bank_dq_d  [NBG-1:0][NBA-1:0];
  logic [CHWIDTH-1:0]        bank_row_q [NBG-1:0][NBA-1:0];
  logic [CHWIDTH-1:0]        bank_row_d [NBG-1:0][NBA-1:0];
  logic [COLWIDTH-1:0]       bank_col_q [NBG-1:0][NBA-1:0];
  logic [COLWIDTH-1:0]       bank_col_d [NBG-1:0][NBA-1:0];

  logic                      accept;
  logic [TW:0]               tick_p1;
  logic                      cap_en;
  logic [LBL-1:0]            cap_beat;
  logic [LBL-1:0]            beat;
  logic                      drive;
  logic [COLWIDTH-1:0]       beat_col;
  logic [DW-1:0]             beat_dq;

  assign accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bg_d    = bg_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = cmd_we ? S_WRITE : S_READ;
          tick_d  = '0;
          bg_d    = cmd_bg;
          ba_d    = cmd_ba;
          row_d   = cmd_row;
          col_d   = cmd_col;
          wdata_d = cmd_wdata;
        end
      end
      S_WRITE: begin
        if (tick_q == BEAT_LAST) begin
          state_d = S_RECOVER;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == BEAT_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tick_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Beat k is presented while tick == k and sampled RDLAT-1 ticks later.
  always_comb begin
    tick_p1  = {1'b0, tick_q} + 1'b1;
    cap_en   = ((state_q == S_READ) || (state_q == S_DRAIN)) &&
               (tick_p1 >= CAP_LO) && (tick_p1 < CAP_HI);
    cap_beat = LBL'(tick_p1 - CAP_LO);
    cap_d    = cap_q;
    if (cap_en) cap_d[int'(cap_beat)*DW +: DW] = dqout[bg_q][ba_q];
    rd_valid_d = (state_q == S_DRAIN) && (tick_q == VALID_TICK);
    rd_data_d  = rd_valid_d ? cap_q : rd_data_q;
  end

  // Chip-facing values are computed from next state so the registers show beat k during its cycle.
  always_comb begin
    drive    = (state_d == S_WRITE) || (state_d == S_READ);
    beat     = tick_d[LBL-1:0];
    beat_col = (col_d & ~WRAP_MASK) | ((col_d + COLWIDTH'(beat)) & WRAP_MASK);
    beat_dq  = wdata_d[int'(beat)*DW +: DW];
    for (int g = 0; g < NBG; g++) begin
      for (int b = 0; b < NBA; b++) begin
        bank_we_d[g][b]  = 1'b0;
        bank_dq_d[g][b]  = '0;
        bank_row_d[g][b] = '0;
        bank_col_d[g][b] = '0;
      end
    end
    if (drive) begin
      bank_we_d[bg_d][ba_d]  = (state_d == S_WRITE);
      bank_dq_d[bg_d][ba_d]  = (state_d == S_WRITE) ? beat_dq : '0;
      bank_row_d[bg_d][ba_d] = row_d;
      bank_col_d[bg_d][ba_d] = beat_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bg_q       <= '0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      bank_we_q  <= '{default: 1'b0};
      bank_dq_q  <= '{default: '0};
      bank_row_q <= '{default: '0};
      bank_col_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wdata_q    <= wdata_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bank_we_q  <= bank_we_d;
      bank_dq_q  <= bank_dq_d;
      bank_row_q <= bank_row_d;
      bank_col_q <= bank_col_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_o_wr   = bank_we_q;
  assign dqin      = bank_dq_q;
  assign row       = bank_row_q;
  assign column    = bank_col_q;

endmodule

// File: tb/tb_bank_burst_sequencer.sv
// Directed bench for bank_burst_sequencer: a vector table of bursts plus hand sequences
// for back-to-back commands, mid-burst reset and first-edge acceptance after reset.
module tb_bank_burst_sequencer;
  localparam int BGW = 2, BAW = 2, CW = 10, RW = 5, DW = 4, BL = 8, RDLAT = 1;
  localparam int NBG = 4, NBA = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_we = 1'b0;
  logic [BGW-1:0]  cmd_bg = '0;
  logic [BAW-1:0]  cmd_ba = '0;
  logic [RW-1:0]   cmd_row = '0;
  logic [CW-1:0]   cmd_col = '0;
  logic [BL*DW-1:0] cmd_wdata = '0;
  logic            rd_valid;
  logic [BL*DW-1:0] rd_data;
  logic            rd_o_wr [NBG-1:0][NBA-1:0];
  logic [DW-1:0]   dqin    [NBG-1:0][NBA-1:0];
  logic [RW-1:0]   row     [NBG-1:0][NBA-1:0];
  logic [CW-1:0]   column  [NBG-1:0][NBA-1:0];
  logic [DW-1:0]   dqout   [NBG-1:0][NBA-1:0];

  bank_burst_sequencer #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .COLWIDTH(CW), .CHWIDTH(RW),
    .DEVICE_WIDTH(DW), .BL(BL), .RDLAT(RDLAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_o_wr(rd_o_wr), .dqin(dqin), .row(row), .column(column), .dqout(dqout)
  );

  always #5 clk = ~clk;

  // Simple Chip stand-in: combinational read (RDLAT = 1), write on the clock edge.
  bit [DW-1:0] mem [NBG*NBA][1<<RW][1<<CW];

  for (genvar g = 0; g < NBG; g++) begin : g_bg
    for (genvar b = 0; b < NBA; b++) begin : g_ba
      assign dqout[g][b] = mem[g*NBA+b][row[g][b]][column[g][b]];
    end
  end

  always @(posedge clk)
    for (int g = 0; g < NBG; g++)
      for (int b = 0; b < NBA; b++)
        if (rd_o_wr[g][b] === 1'b1) mem[g*NBA+b][row[g][b]][column[g][b]] <= dqin[g][b];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int other_active(input int sbg, input int sba);
    int n = 0;
    for (int g = 0; g < NBG; g++)
      for (int b = 0; b < NBA; b++)
        if (!(g == sbg && b == sba) &&
            (rd_o_wr[g][b] !== 1'b0 || dqin[g][b] !== '0 || row[g][b] !== '0 || column[g][b] !== '0))
          n++;
    return n;
  endfunction

  typedef struct {
    logic           we;
    logic [1:0]     bg;
    logic [1:0]     ba;
    logic [4:0]     rw;
    logic [9:0]     col;
    logic [31:0]    wdata;
    logic [31:0]    exp_rd;
    logic [7:0][9:0] exp_cols;
  } vec_t;

  localparam logic [79:0] COLS_0   = {10'h007, 10'h006, 10'h005, 10'h004, 10'h003, 10'h002, 10'h001, 10'h000};
  localparam logic [79:0] COLS_3FD = {10'h3FC, 10'h3FB, 10'h3FA, 10'h3F9, 10'h3F8, 10'h3FF, 10'h3FE, 10'h3FD};
  localparam logic [79:0] COLS_3F8 = {10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC, 10'h3FB, 10'h3FA, 10'h3F9, 10'h3F8};
  localparam logic [79:0] COLS_5   = {10'h004, 10'h003, 10'h002, 10'h001, 10'h000, 10'h007, 10'h006, 10'h005};

  vec_t vecs [9];

  task automatic run_cmd(input vec_t v, input int idx);
    int sbg;
    int sba;
    int n;
    logic [DW-1:0] eb;
    sbg = int'(v.bg);
    sba = int'(v.ba);
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d ready before accept", idx), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_bg    = v.bg;
    cmd_ba    = v.ba;
    cmd_row   = v.rw;
    cmd_col   = v.col;
    cmd_wdata = v.wdata;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = ~v.we;
    cmd_bg    = ~v.bg;
    cmd_ba    = ~v.ba;
    cmd_row   = ~v.rw;
    cmd_col   = ~v.col;
    cmd_wdata = ~v.wdata;
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      eb = v.we ? DW'(v.wdata >> (k*DW)) : '0;
      check($sformatf("v%0d beat%0d rd_o_wr", idx, k), rd_o_wr[sbg][sba], v.we);
      check($sformatf("v%0d beat%0d row", idx, k), row[sbg][sba], v.rw);
      check($sformatf("v%0d beat%0d column", idx, k), column[sbg][sba], v.exp_cols[k]);
      check($sformatf("v%0d beat%0d dqin", idx, k), dqin[sbg][sba], eb);
      check($sformatf("v%0d beat%0d cmd_ready", idx, k), cmd_ready, 0);
      check($sformatf("v%0d beat%0d rd_valid", idx, k), rd_valid, 0);
      check($sformatf("v%0d beat%0d other banks", idx, k), other_active(sbg, sba), 0);
    end
    if (v.we) begin
      @(negedge clk);
      check($sformatf("v%0d recover banks", idx), other_active(-1, -1), 0);
      check($sformatf("v%0d recover cmd_ready", idx), cmd_ready, 0);
      @(negedge clk);
      check($sformatf("v%0d ready after write", idx), cmd_ready, 1);
    end else begin
      for (int i = 0; i < RDLAT; i++) begin
        @(negedge clk);
        check($sformatf("v%0d drain%0d rd_valid", idx, i), rd_valid, 0);
        check($sformatf("v%0d drain%0d cmd_ready", idx, i), cmd_ready, 0);
        check($sformatf("v%0d drain%0d banks", idx, i), other_active(-1, -1), 0);
      end
      @(negedge clk);
      check($sformatf("v%0d rd_valid pulse", idx), rd_valid, 1);
      check($sformatf("v%0d rd_data", idx), rd_data, v.exp_rd);
      check($sformatf("v%0d ready during pulse", idx), cmd_ready, 0);
      @(negedge clk);
      check($sformatf("v%0d rd_valid drop", idx), rd_valid, 0);
      check($sformatf("v%0d rd_data hold", idx), rd_data, v.exp_rd);
      check($sformatf("v%0d ready after read", idx), cmd_ready, 1);
    end
  endtask

  initial begin
    int n;
    int seen_valid;
    int seen_active;

    vecs[0] = '{we:1'b1, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h000, wdata:32'h27C51D93, exp_rd:32'h0,        exp_cols:COLS_0};
    vecs[1] = '{we:1'b0, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h000, wdata:32'h0,        exp_rd:32'h27C51D93, exp_cols:COLS_0};
    vecs[2] = '{we:1'b1, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h3FD, wdata:32'h10FEDCBA, exp_rd:32'h0,        exp_cols:COLS_3FD};
    vecs[3] = '{we:1'b0, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h3FD, wdata:32'h0,        exp_rd:32'h10FEDCBA, exp_cols:COLS_3FD};
    vecs[4] = '{we:1'b0, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h3F8, wdata:32'h0,        exp_rd:32'hCBA10FED, exp_cols:COLS_3F8};
    vecs[5] = '{we:1'b1, bg:2'd3, ba:2'd0, rw:5'd1, col:10'h000, wdata:32'h55AA0FF0, exp_rd:32'h0,        exp_cols:COLS_0};
    vecs[6] = '{we:1'b0, bg:2'd3, ba:2'd0, rw:5'd1, col:10'h000, wdata:32'h0,        exp_rd:32'h55AA0FF0, exp_cols:COLS_0};
    vecs[7] = '{we:1'b0, bg:2'd1, ba:2'd1, rw:5'd1, col:10'h000, wdata:32'h0,        exp_rd:32'h27C51D93, exp_cols:COLS_0};
    vecs[8] = '{we:1'b0, bg:2'd1, ba:2'd1, rw:5'd2, col:10'h000, wdata:32'h0,        exp_rd:32'h0,        exp_cols:COLS_0};

    #1 rst = 1'b1;
    #1;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset banks", other_active(-1, -1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

    // cmd_valid held high: write then read, second accept right at the first idle cycle
    @(negedge clk);
    check("b2b ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we = 1'b1; cmd_bg = 2'd2; cmd_ba = 2'd3; cmd_row = 5'd7; cmd_col = 10'h005; cmd_wdata = 32'h13579BDF;
    @(posedge clk);
    #1;
    cmd_we = 1'b0; cmd_wdata = 32'hFFFFFFFF;
    for (int c = 1; c <= BL + 1; c++) begin
      @(negedge clk);
      check($sformatf("b2b busy c%0d", c), cmd_ready, 0);
      if (c <= BL) check($sformatf("b2b write col c%0d", c), column[2][3], COLS_5[(c-1)*10 +: 10]);
    end
    @(negedge clk);
    check("b2b ready at T+BL+2", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b read accepted", cmd_ready, 0);
    check("b2b read rd_o_wr", rd_o_wr[2][3], 0);
    check("b2b read row", row[2][3], 7);
    check("b2b read col", column[2][3], 10'h005);
    n = 0;
    while (rd_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b rd_valid latency", n, BL + 1);
    check("b2b rd_data", rd_data, 32'h13579BDF);

    // reset while a read is at beat 3
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = 1'b0; cmd_bg = 2'd1; cmd_ba = 2'd1; cmd_row = 5'd1; cmd_col = 10'h000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort beat3 column", column[1][1], 10'h003);
    #2 rst = 1'b1;
    #1;
    check("abort banks zero", other_active(-1, -1), 0);
    check("abort cmd_ready", cmd_ready, 1);
    check("abort rd_valid", rd_valid, 0);
    check("abort rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    seen_active = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_valid !== 1'b0) seen_valid++;
      seen_active += other_active(-1, -1);
    end
    check("abort no rd_valid", seen_valid, 0);
    check("abort no bank activity", seen_active, 0);
    check("abort idle ready", cmd_ready, 1);

    // command accepted at the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_we = 1'b0; cmd_bg = 2'd1; cmd_ba = 2'd1; cmd_row = 5'd1; cmd_col = 10'h3FD;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("post-reset accept row", row[1][1], 1);
    check("post-reset accept col", column[1][1], 10'h3FD);
    check("post-reset accept rd_o_wr", rd_o_wr[1][1], 0);
    n = 0;
    while (rd_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("post-reset rd_valid latency", n, BL + 1);
    check("post-reset rd_data", rd_data, 32'h10FEDCBA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
